// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - rounding-mode enum and saturation-limit helpers shared by the requantizer
package fixed_point_pkg;

  typedef enum logic [1:0] {
    TRUNC     = 2'd0,
    HALF_UP   = 2'd1,
    HALF_EVEN = 2'd2,
    TO_ZERO   = 2'd3
  } round_mode_e;

  // Limits are built at full width and sliced down by the user.
  localparam int LIMIT_W = 64;

  function automatic logic [LIMIT_W-1:0] sat_max(input int width, input bit is_signed);
    logic [LIMIT_W-1:0] v;
    v = '0;
    for (int i = 0; i < LIMIT_W; i++) begin
      if (i < width - (is_signed ? 1 : 0)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [LIMIT_W-1:0] sat_min(input int width, input bit is_signed);
    logic [LIMIT_W-1:0] v;
    v = '0;
    if (is_signed && width > 0 && width <= LIMIT_W) v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one-sample round decision (stage 1) and add+saturate (stage 2), purely combinational
module requant_lane
  import fixed_point_pkg::*;
#(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 8,
  parameter int IS_SIGNED = 1
) (
  input  logic [WIDTH_IN-1:0]  sample_i,
  input  round_mode_e          mode_i,
  output logic [WIDTH_OUT-1:0] trunc_o,
  output logic                 round_up_o,
  output logic                 sign_o,
  input  logic [WIDTH_OUT-1:0] trunc_i,
  input  logic                 round_up_i,
  input  logic                 sign_i,
  output logic [WIDTH_OUT-1:0] data_o,
  output logic                 sat_o
);

  localparam int DIFF = WIDTH_IN - WIDTH_OUT;
  localparam logic [LIMIT_W-1:0]   MAX_FULL = sat_max(WIDTH_OUT, IS_SIGNED != 0);
  localparam logic [LIMIT_W-1:0]   MIN_FULL = sat_min(WIDTH_OUT, IS_SIGNED != 0);
  localparam logic [WIDTH_OUT-1:0] MAX_C    = MAX_FULL[WIDTH_OUT-1:0];
  localparam logic [WIDTH_OUT-1:0] MIN_C    = MIN_FULL[WIDTH_OUT-1:0];

  assign trunc_o = sample_i[WIDTH_IN-1:DIFF];
  assign sign_o  = (IS_SIGNED != 0) && sample_i[WIDTH_IN-1];

  if (DIFF == 0) begin : g_passthru
    assign round_up_o = 1'b0;
  end else begin : g_round
    localparam logic [LIMIT_W-1:0] HALF_FULL = 64'd1 << (DIFF - 1);
    localparam logic [DIFF-1:0]    HALF      = HALF_FULL[DIFF-1:0];
    logic [DIFF-1:0] frac;

    assign frac = sample_i[DIFF-1:0];

    always_comb begin
      case (mode_i)
        HALF_UP:   round_up_o = (frac >= HALF);
        HALF_EVEN: round_up_o = (frac > HALF) || ((frac == HALF) && sample_i[DIFF]);
        TO_ZERO:   round_up_o = sign_o && (frac != '0);
        default:   round_up_o = 1'b0;
      endcase
    end
  end

  // sign_i is zero for unsigned samples, so this is sign- or zero-extension as appropriate.
  logic [WIDTH_OUT:0] sum;
  assign sum = {sign_i, trunc_i} + {{WIDTH_OUT{1'b0}}, round_up_i};

  always_comb begin
    data_o = sum[WIDTH_OUT-1:0];
    sat_o  = 1'b0;
    if (IS_SIGNED != 0) begin
      if (sum[WIDTH_OUT] != sum[WIDTH_OUT-1]) begin
        sat_o  = 1'b1;
        data_o = sum[WIDTH_OUT] ? MIN_C : MAX_C;
      end
    end else if (sum[WIDTH_OUT]) begin
      sat_o  = 1'b1;
      data_o = MAX_C;
    end
  end

endmodule

// File: rtl/fixed_point_requantizer.sv
// rtl/fixed_point_requantizer.sv - multi-lane round/saturate requantizer with two-stage valid/ready pipeline
module fixed_point_requantizer
  import fixed_point_pkg::*;
#(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 8,
  parameter int CHANNELS  = 4,
  parameter int IS_SIGNED = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH_IN-1:0]  in_data,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*WIDTH_OUT-1:0] out_data,
  output logic [CHANNELS-1:0]           out_sat,
  output logic [CNT_WIDTH-1:0]          sat_count,
  input  logic                          sat_clr
);

  if (WIDTH_IN <= 0) begin : g_bad_width_in
    $error("WIDTH_IN must be > 0");
  end
  if (WIDTH_OUT <= 0 || WIDTH_OUT > WIDTH_IN) begin : g_bad_width_out
    $error("WIDTH_OUT must satisfy 0 < WIDTH_OUT <= WIDTH_IN");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be >= 1");
  end

  localparam int DW = CHANNELS * WIDTH_OUT;

  logic                 s1_valid_q, s1_valid_d;
  logic [DW-1:0]        s1_trunc_q, s1_trunc_d;
  logic [CHANNELS-1:0]  s1_round_q, s1_round_d;
  logic [CHANNELS-1:0]  s1_sign_q,  s1_sign_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [DW-1:0]        s2_data_q,  s2_data_d;
  logic [CHANNELS-1:0]  s2_sat_q,   s2_sat_d;
  logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  logic [DW-1:0]       lane_trunc, lane_data;
  logic [CHANNELS-1:0] lane_round, lane_sign, lane_sat;
  logic                s2_ready, s1_adv, in_fire, sat_inc;
  round_mode_e         mode_e;

  assign mode_e = round_mode_e'(in_mode);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    requant_lane #(
      .WIDTH_IN  (WIDTH_IN),
      .WIDTH_OUT (WIDTH_OUT),
      .IS_SIGNED (IS_SIGNED)
    ) u_lane (
      .sample_i   (in_data[ch*WIDTH_IN +: WIDTH_IN]),
      .mode_i     (mode_e),
      .trunc_o    (lane_trunc[ch*WIDTH_OUT +: WIDTH_OUT]),
      .round_up_o (lane_round[ch]),
      .sign_o     (lane_sign[ch]),
      .trunc_i    (s1_trunc_q[ch*WIDTH_OUT +: WIDTH_OUT]),
      .round_up_i (s1_round_q[ch]),
      .sign_i     (s1_sign_q[ch]),
      .data_o     (lane_data[ch*WIDTH_OUT +: WIDTH_OUT]),
      .sat_o      (lane_sat[ch])
    );
  end

  // Each stage refills in the same cycle its contents leave, giving one beat per cycle.
  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign sat_inc  = s2_valid_q && out_ready && (|s2_sat_q);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_trunc_d  = s1_trunc_q;
    s1_round_d  = s1_round_q;
    s1_sign_d   = s1_sign_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_sat_d    = s2_sat_q;
    sat_count_d = sat_count_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_trunc_d = lane_trunc;
      s1_round_d = lane_round;
      s1_sign_d  = lane_sign;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lane_data;
        s2_sat_d  = lane_sat;
      end
    end

    if (sat_clr) begin
      sat_count_d = '0;
    end else if (sat_inc && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_trunc_q  <= '0;
      s1_round_q  <= '0;
      s1_sign_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_trunc_q  <= s1_trunc_d;
      s1_round_q  <= s1_round_d;
      s1_sign_q   <= s1_sign_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: doc/fixed_point_requantizer.md
FIXED_POINT_REQUANTIZER -- requirements
Module: fixed_point_requantizer

Interface
REQ-001 Parameter WIDTH_IN, default 16: input sample width per channel; SHALL be > 0.
REQ-002 Parameter WIDTH_OUT, default 8: output sample width per channel; SHALL satisfy 0 < WIDTH_OUT <= WIDTH_IN, else elaboration $error.
REQ-003 Parameter CHANNELS, default 4: lanes processed in lockstep per beat; SHALL be >= 1.
REQ-004 Parameter IS_SIGNED, default 1: 1 = two's-complement samples, 0 = unsigned.
REQ-005 Parameter CNT_WIDTH, default 16: width of the saturation event counter.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  block can accept a beat this cycle.
REQ-010 in_data  in  CHANNELS*WIDTH_IN  packed samples; channel 0 in the LSBs.
REQ-011 in_mode  in  2  rounding mode, sampled with the beat: 0 TRUNC, 1 HALF_UP, 2 HALF_EVEN, 3 TO_ZERO.
REQ-012 out_valid  out  1  output beat valid.
REQ-013 out_ready  in  1  downstream accepts the beat.
REQ-014 out_data  out  CHANNELS*WIDTH_OUT  rounded, saturated samples; same packing.
REQ-015 out_sat  out  CHANNELS  per-lane flag: saturation clamped this beat.
REQ-016 sat_count  out  CNT_WIDTH  count of beats with any out_sat bit set.
REQ-017 sat_clr  in  1  synchronous clear of sat_count.

Function
REQ-018 Beat transfers on input when in_valid && in_ready, on output when out_valid && out_ready; no beat is dropped or duplicated.
REQ-019 Two register stages: S1 holds truncated value, round_up bit and sign per lane; S2 holds saturated result; latency SHALL be 2 cycles under no backpressure.
REQ-020 Each stage loads when it is empty or its own contents leave this cycle; in_ready = !S1_valid || S1 advances into S2 this cycle; full throughput of 1 beat/cycle.
REQ-021 out_data, out_sat and out_valid SHALL be register outputs and stay stable while out_valid && !out_ready.
REQ-022 DIFF = WIDTH_IN-WIDTH_OUT; trunc = in[WIDTH_IN-1:DIFF]; f = in[DIFF-1:0]; H = 2^(DIFF-1).
REQ-023 round_up: TRUNC 0; HALF_UP f>=H; HALF_EVEN f>H or (f==H and trunc[0]); TO_ZERO (IS_SIGNED and sign=1 and f!=0).
REQ-024 Sum = extend(trunc) + round_up in WIDTH_OUT+1 bits; sign extension if IS_SIGNED, zero extension otherwise.
REQ-025 Signed: if sum[WIDTH_OUT] != sum[WIDTH_OUT-1], clamp to max positive or min negative per sum[WIDTH_OUT] and set out_sat; unsigned: if sum[WIDTH_OUT] set, clamp to all-ones and set out_sat.
REQ-026 DIFF==0: mode ignored, data passed unchanged, out_sat=0, same 2-cycle latency and handshake.
REQ-027 sat_count increments by 1 on each output transfer with |out_sat; holds at all-ones (no wrap).
REQ-028 sat_clr and an increment in the same cycle: clear wins, sat_count=0.
REQ-029 Mode is per beat; mixed modes in flight SHALL each use their own captured mode.

Reset
REQ-030 rst_n low: S1_valid, S2_valid, out_valid, out_sat, sat_count -> 0 immediately; out_data -> 0; in_ready -> 1 after release.
REQ-031 Reset mid-stream discards all in-flight beats; first beat after release emerges 2 cycles after acceptance.

Structure
REQ-032 Shared package fixed_point_pkg SHALL hold the rounding-mode enum (TRUNC, HALF_UP, HALF_EVEN, TO_ZERO) and saturation-limit helper constants.
REQ-033 One sub-module requant_lane (combinational round+saturate for one sample, parametrised by widths, IS_SIGNED), instantiated CHANNELS times via generate; pipeline/handshake in the top.

Verification (WIDTH_IN=8, WIDTH_OUT=4, IS_SIGNED=1, CHANNELS=2)
REQ-034 HALF_EVEN lanes 0x18, 0x28 -> out 0x2, 0x2; HALF_UP same inputs -> 0x2, 0x3; out_sat=0, 2 cycles after acceptance.
REQ-035 HALF_UP 0x7F, TRUNC 0x80 -> lane0 0x7 with out_sat[0]=1, lane1 0x8 with out_sat[1]=0; sat_count 0->1.
REQ-036 TO_ZERO 0xE8 (-1.5) -> 0xF (-1); TRUNC 0xE8 -> 0xE (-2); HALF_EVEN 0xF8 (-0.5) -> 0x0.
REQ-037 Continuous stream of 10 beats, out_ready low cycles 3-5 -> in_ready low once both stages full, all 10 beats out in order, held data stable.
REQ-038 sat_clr pulsed on same cycle as saturating output transfer -> sat_count=0; 2^CNT_WIDTH+3 saturating beats (CNT_WIDTH=4) -> sat_count holds 0xF.
REQ-039 rst_n asserted with 2 beats in flight -> out_valid drops asynchronously, those beats never appear; next accepted beat out after 2 cycles.
